// File: rtl/wb_trace_capture.sv
// Captures nonzero write-back samples into a FIFO for CYCLE_LIMIT cycles after a start pulse,
// then drains. Tracks pushed and lost sample counts per window.
module wb_trace_capture #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned CYCLE_LIMIT = 427
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     start,
    input  logic [31:0]              wr_data,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [31:0]              rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              captured,
    output logic [15:0]              dropped,
    output logic                     overflow,
    output logic                     done
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCapture = 2'd1;
    localparam logic [1:0] StDrain   = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    localparam logic [AW:0]   FullLvl = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LvlOne  = (AW + 1)'(1);
    localparam logic [AW-1:0] PtrOne  = AW'(1);
    localparam logic [15:0]   LastCnt = 16'(CYCLE_LIMIT - 1);
    localparam logic [15:0]   SatMax  = 16'hffff;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   captured_q, captured_d;
    logic [15:0]   dropped_q, dropped_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   mem [DEPTH];

    logic pop, push_req, push, drop, full, start_ok, last;

    assign full     = (level_q == FullLvl);
    assign rd_valid = (level_q != '0);
    assign pop      = rd_valid && rd_ready;
    assign push_req = (state_q == StCapture) && (wr_data != 32'd0);
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    assign last     = (cnt_q == LastCnt);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        dropped_d  = dropped_q;
        overflow_d = overflow_q;
        level_d    = level_q;

        case (state_q)
            StIdle, StDone: if (start) state_d = StCapture;
            StCapture:      if (last) state_d = StDrain;
            StDrain:        if (level_q == '0) state_d = StDone;
            default:        state_d = StIdle;
        endcase

        if (start_ok) begin
            cnt_d      = '0;
            captured_d = '0;
            dropped_d  = '0;
            overflow_d = 1'b0;
        end else begin
            if (state_q == StCapture) cnt_d = cnt_q + 16'd1;
            if (push && (captured_q != SatMax)) captured_d = captured_q + 16'd1;
            if (drop) begin
                overflow_d = 1'b1;
                if (dropped_q != SatMax) dropped_d = dropped_q + 16'd1;
            end
        end

        if (push && !pop) begin
            level_d = level_q + LvlOne;
        end else if (pop && !push) begin
            level_d = level_q - LvlOne;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            captured_q <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    // Storage is not reset; only the pointers define valid contents.
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = mem[rd_ptr_q];
    assign level    = level_q;
    assign captured = captured_q;
    assign dropped  = dropped_q;
    assign overflow = overflow_q;
    assign done     = (state_q == StDone);

endmodule

// File: tb/tb_wb_trace_capture.sv
// Directed bench for wb_trace_capture with DEPTH=4 and a 10-cycle window.
module tb_wb_trace_capture;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [31:0] wr_data;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [2:0]  level;
    logic [15:0] captured;
    logic [15:0] dropped;
    logic        overflow;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic        track = 1'b0;
    logic [31:0] exp_q[$];
    int          n_popped = 0;
    int          max_lvl  = 0;
    int          tgl      = 0;

    wb_trace_capture #(
        .DEPTH      (4),
        .CYCLE_LIMIT(10)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .start   (start),
        .wr_data (wr_data),
        .rd_ready(rd_ready),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .level   (level),
        .captured(captured),
        .dropped (dropped),
        .overflow(overflow),
        .done    (done)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive one cycle of inputs, check any pop against the expected order, then clock.
    task automatic cyc(input logic [31:0] d, input logic rr, input logic st);
        wr_data  = d;
        rd_ready = rr;
        start    = st;
        if (track && rd_valid && rd_ready) begin
            if (exp_q.size() > 0) check_eq("wrap_order", rd_data, exp_q.pop_front());
            else                  check_eq("wrap_extra_pop", rd_data, 32'd0);
            n_popped++;
        end
        tick();
        if (int'(level) > max_lvl) max_lvl = int'(level);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            cyc(32'd0, rd_ready, 1'b0);
            n++;
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    // Sparse window; zeros pad it out to the 10-cycle window.
    task automatic run_sparse(input string tag);
        logic [31:0] vec [10] = '{1, 0, 2, 0, 0, 3, 0, 4, 0, 0};
        cyc(32'd0, 1'b1, 1'b1);
        check_eq({tag, "_start_done"}, 32'(done), 32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(vec[i], 1'b1, 1'b0);
            if (vec[i] != 0) begin
                check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
                check_eq({tag, "_data"}, rd_data, vec[i]);
            end else begin
                check_eq({tag, "_empty"}, 32'(rd_valid), 32'd0);
            end
        end
        wait_done({tag, "_done"}, 20);
        check_eq({tag, "_captured"}, 32'(captured), 32'd4);
        check_eq({tag, "_dropped"}, 32'(dropped), 32'd0);
        check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
        check_eq({tag, "_level"}, 32'(level), 32'd0);
    endtask

    initial begin
        logic [31:0] w1 [10] = '{11, 12, 0, 13, 14, 0, 15, 16, 0, 17};
        logic [31:0] w2 [10] = '{18, 0, 19, 0, 20, 0, 21, 0, 0, 0};
        Reset    = 1'b0;
        start    = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        repeat (2) tick();
        check_eq("rst_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_captured", 32'(captured), 32'd0);
        check_eq("rst_dropped", 32'(dropped), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        Reset = 1'b1;
        tick();

        run_sparse("sparse");

        // Overfill with consumer stalled, then drain.
        cyc(32'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) cyc(32'(i), 1'b0, 1'b0);
        check_eq("ovf_level", 32'(level), 32'd4);
        check_eq("ovf_dropped", 32'(dropped), 32'd6);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_captured", 32'(captured), 32'd4);
        check_eq("ovf_not_done", 32'(done), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            check_eq("ovf_drain_data", rd_data, 32'(k));
            cyc(32'd0, 1'b1, 1'b0);
        end
        wait_done("ovf_done", 5);
        check_eq("ovf_drained", 32'(level), 32'd0);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);

        // Push into a full FIFO while the head is popped.
        cyc(32'd0, 1'b0, 1'b1);
        for (int i = 5; i <= 8; i++) cyc(32'(i), 1'b0, 1'b0);
        check_eq("full_level", 32'(level), 32'd4);
        cyc(32'd9, 1'b1, 1'b0);
        check_eq("fullpp_level", 32'(level), 32'd4);
        check_eq("fullpp_dropped", 32'(dropped), 32'd0);
        check_eq("fullpp_captured", 32'(captured), 32'd5);
        check_eq("fullpp_overflow", 32'(overflow), 32'd0);
        for (int k = 6; k <= 9; k++) begin
            check_eq("fullpp_order", rd_data, 32'(k));
            cyc(32'd0, 1'b1, 1'b0);
        end
        check_eq("fullpp_empty", 32'(level), 32'd0);
        wait_done("fullpp_done", 10);

        // Pointer wrap over two windows with a toggling consumer.
        for (int v = 11; v <= 21; v++) exp_q.push_back(32'(v));
        track   = 1'b1;
        max_lvl = 0;
        cyc(32'd0, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) cyc(w1[c], (c % 2) == 0, 1'b0);
        for (int n = 0; n < 20 && !done; n++) begin
            cyc(32'd0, (tgl % 2) == 0, 1'b0);
            tgl++;
        end
        check_eq("wrap_w1_done", 32'(done), 32'd1);
        cyc(32'd0, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) cyc(w2[c], (c % 2) == 0, 1'b0);
        for (int n = 0; n < 20 && !done; n++) begin
            cyc(32'd0, (tgl % 2) == 0, 1'b0);
            tgl++;
        end
        track = 1'b0;
        check_eq("wrap_w2_done", 32'(done), 32'd1);
        check_eq("wrap_popped", 32'(n_popped), 32'd11);
        check_eq("wrap_dropped", 32'(dropped), 32'd0);
        check_eq("wrap_captured", 32'(captured), 32'd4);
        check_eq("wrap_never_full", 32'(max_lvl < 4), 32'd1);

        // Start pulses inside CAPTURE and DRAIN must not restart the window.
        cyc(32'd0, 1'b1, 1'b1);
        for (int c = 0; c < 10; c++) cyc(32'(100 + c), 1'b1, c == 3);
        check_eq("restart_captured", 32'(captured), 32'd10);
        check_eq("restart_level", 32'(level), 32'd1);
        check_eq("restart_not_done", 32'(done), 32'd0);
        cyc(32'h55, 1'b0, 1'b1);
        check_eq("drainstart_level", 32'(level), 32'd1);
        check_eq("drainstart_captured", 32'(captured), 32'd10);
        check_eq("drainstart_done", 32'(done), 32'd0);
        cyc(32'h66, 1'b0, 1'b0);
        check_eq("drain_ignore_wr", 32'(level), 32'd1);
        check_eq("drain_head", rd_data, 32'd109);
        cyc(32'd0, 1'b1, 1'b0);
        wait_done("restart_done", 5);
        check_eq("restart_final_cap", 32'(captured), 32'd10);

        // Asynchronous reset in the middle of a window.
        cyc(32'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) cyc(32'(i), 1'b0, 1'b0);
        check_eq("prerst_level", 32'(level), 32'd3);
        Reset = 1'b0;
        #1;
        check_eq("arst_valid", 32'(rd_valid), 32'd0);
        check_eq("arst_level", 32'(level), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_captured", 32'(captured), 32'd0);
        start = 1'b1;
        repeat (2) tick();
        check_eq("arst_start_level", 32'(level), 32'd0);
        check_eq("arst_start_valid", 32'(rd_valid), 32'd0);
        start = 1'b0;
        Reset = 1'b1;
        tick();
        check_eq("postrst_idle_valid", 32'(rd_valid), 32'd0);
        run_sparse("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1);
    end

endmodule
